// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: two requester ports, the shared synchronous RAM port,
// and status outputs. The arbiter uses the slave modport; the environment uses master.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [1:0]        grant;
    logic              busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output grant, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  grant, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-port synchronous data RAM (IDLE/ISSUE/WAIT/DONE).
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise m0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0]        req_vec;
    logic [1:0]        we_vec;
    logic [ADDR_W-1:0] addr_vec  [2];
    logic [DATA_W-1:0] wdata_vec [2];
    logic [1:0]        ack_vec;
    logic [DATA_W-1:0] rdata_vec [2];
    logic              win_m1;

    assign req_vec      = {bus.m1_req, bus.m0_req};
    assign we_vec       = {bus.m1_we, bus.m0_we};
    assign addr_vec[0]  = bus.m0_addr;
    assign addr_vec[1]  = bus.m1_addr;
    assign wdata_vec[0] = bus.m0_wdata;
    assign wdata_vec[1] = bus.m1_wdata;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // last_grant_q = 1 means m1 owned the previous grant, so m0 takes the next tie
    logic last_grant_q, last_grant_d;

    always_comb begin
        win_m1 = 1'b0;
        if (req_vec == 2'b11) begin
            win_m1 = ~last_grant_q;
        end else begin
            win_m1 = req_vec[1];
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && req_vec != 2'b00) begin
            last_grant_d = win_m1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    always_comb begin
        win_m1 = req_vec[1] & ~req_vec[0];
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_vec != 2'b00) begin
                    grant_d = win_m1 ? 2'b10 : 2'b01;
                    we_d    = we_vec[win_m1];
                    addr_d  = addr_vec[win_m1];
                    wdata_d = wdata_vec[win_m1];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // RAM output is valid in this cycle; writes leave the read register untouched
                if (!we_q) begin
                    rdata_d = bus.mem_rdata;
                end
                state_d = DONE;
            end
            DONE: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master_out
            assign ack_vec[gi]   = (state_q == DONE) & grant_q[gi];
            assign rdata_vec[gi] = grant_q[gi] ? rdata_q : '0;
        end
    endgenerate

    assign bus.m0_ack    = ack_vec[0];
    assign bus.m1_ack    = ack_vec[1];
    assign bus.m0_rdata  = rdata_vec[0];
    assign bus.m1_rdata  = rdata_vec[1];

    assign bus.mem_en    = (state_q == ISSUE);
    assign bus.mem_we    = (state_q == ISSUE) & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural synchronous RAM.
// Tie-break expectations follow DMEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_dmem_arbiter;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: unwritten locations return a fixed pattern per address
    logic [DATA_W-1:0] ram [16384];
    bit                written [16384];
    logic [DATA_W-1:0] rd_q;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        case (a)
            14'h010: pat = 32'hDEADBEEF;
            14'h001: pat = 32'h11111111;
            14'h002: pat = 32'h22222222;
            14'h020: pat = 32'hA5A5A5A5;
            14'h021: pat = 32'h5A5A5A5A;
            14'h030: pat = 32'h33333333;
            14'h040: pat = 32'h44444444;
            default: pat = 32'h0BAD0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr]     <= bus.mem_wdata;
                written[bus.mem_addr] <= 1'b1;
            end else begin
                rd_q <= written[bus.mem_addr] ? ram[bus.mem_addr] : pat(bus.mem_addr);
            end
        end
    end
    assign bus.mem_rdata = rd_q;

    always @(negedge clk) begin
        if (bus.m0_ack) $display("txn m0 ack rdata=%h", bus.m0_rdata);
        if (bus.m1_ack) $display("txn m1 ack rdata=%h", bus.m1_rdata);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m0_drive(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
    endtask

    task automatic m1_drive(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_grant;
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        m0_drive(1'b0, 1'b0, '0, '0);
        m1_drive(1'b0, 1'b0, '0, '0);

        // reset state
        #2;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_grant", bus.grant, 2'b00);
        check("rst_mem_en", bus.mem_en, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 14'h0);
        check("rst_acks", {bus.m0_ack, bus.m1_ack}, 2'b00);
        check("rst_m0_rdata", bus.m0_rdata, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // m0 read of 0x010
        m0_drive(1'b1, 1'b0, 14'h010, 32'h0);
        tick();
        check("r0_issue_en", bus.mem_en, 1'b1);
        check("r0_issue_we", bus.mem_we, 1'b0);
        check("r0_issue_addr", bus.mem_addr, 14'h010);
        check("r0_issue_grant", bus.grant, 2'b01);
        check("r0_issue_busy", bus.busy, 1'b1);
        tick();
        check("r0_wait_en", bus.mem_en, 1'b0);
        check("r0_wait_ack", bus.m0_ack, 1'b0);
        check("r0_wait_grant", bus.grant, 2'b01);
        tick();
        check("r0_done_ack", bus.m0_ack, 1'b1);
        check("r0_done_rdata", bus.m0_rdata, 32'hDEADBEEF);
        check("r0_done_m1", {bus.m1_ack, bus.m1_rdata}, 33'h0);
        check("r0_done_en", bus.mem_en, 1'b0);
        m0_drive(1'b0, 1'b0, '0, '0);
        tick();
        check("r0_idle_ack", bus.m0_ack, 1'b0);
        check("r0_idle_busy", bus.busy, 1'b0);
        check("r0_idle_grant", bus.grant, 2'b00);

        // m1 write of 0x12345678 to 0x3FF
        m1_drive(1'b1, 1'b1, 14'h3FF, 32'h12345678);
        tick();
        check("w1_issue_en", bus.mem_en, 1'b1);
        check("w1_issue_we", bus.mem_we, 1'b1);
        check("w1_issue_addr", bus.mem_addr, 14'h3FF);
        check("w1_issue_wdata", bus.mem_wdata, 32'h12345678);
        check("w1_issue_grant", bus.grant, 2'b10);
        tick();
        check("w1_wait_ack", bus.m1_ack, 1'b0);
        tick();
        check("w1_done_ack", bus.m1_ack, 1'b1);
        check("w1_done_rdata_held", bus.m1_rdata, 32'hDEADBEEF);
        check("w1_done_m0_ack", bus.m0_ack, 1'b0);
        m1_drive(1'b0, 1'b0, '0, '0);
        tick();
        check("w1_idle_ack", bus.m1_ack, 1'b0);

        // read back the written word through m0
        m0_drive(1'b1, 1'b0, 14'h3FF, 32'h0);
        tick(); tick(); tick();
        check("rb_done_ack", bus.m0_ack, 1'b1);
        check("rb_done_rdata", bus.m0_rdata, 32'h12345678);
        m0_drive(1'b0, 1'b0, '0, '0);
        tick();

        // m1 request arriving during m0 WAIT is held off
        m0_drive(1'b1, 1'b0, 14'h020, 32'h0);
        tick();
        tick();
        m1_drive(1'b1, 1'b0, 14'h021, 32'h0);
        tick();
        check("ho_done_m0_ack", bus.m0_ack, 1'b1);
        check("ho_done_m0_rdata", bus.m0_rdata, 32'hA5A5A5A5);
        check("ho_done_m1_ack", bus.m1_ack, 1'b0);
        m0_drive(1'b0, 1'b0, '0, '0);
        tick();
        check("ho_idle_m1_ack", bus.m1_ack, 1'b0);
        check("ho_idle_busy", bus.busy, 1'b0);
        tick();
        check("ho_m1_grant", bus.grant, 2'b10);
        tick(); tick();
        check("ho_m1_ack", bus.m1_ack, 1'b1);
        check("ho_m1_rdata", bus.m1_rdata, 32'h5A5A5A5A);
        m1_drive(1'b0, 1'b0, '0, '0);
        tick();

        // reset during WAIT of an m0 read
        m0_drive(1'b1, 1'b0, 14'h030, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rw_busy", bus.busy, 1'b0);
        check("rw_grant", bus.grant, 2'b00);
        check("rw_mem", {bus.mem_en, bus.mem_we, bus.mem_addr}, 16'h0);
        check("rw_mem_wdata", bus.mem_wdata, 32'h0);
        check("rw_ack_rdata", {bus.m0_ack, bus.m0_rdata}, 33'h0);
        m0_drive(1'b0, 1'b0, '0, '0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("rw_after_ack", bus.m0_ack, 1'b0);
        check("rw_after_busy", bus.busy, 1'b0);
        m0_drive(1'b1, 1'b0, 14'h030, 32'h0);
        tick(); tick(); tick();
        check("rw_fresh_ack", bus.m0_ack, 1'b1);
        check("rw_fresh_rdata", bus.m0_rdata, 32'h33333333);
        m0_drive(1'b0, 1'b0, '0, '0);
        tick();

        // req dropped during ISSUE still completes
        m0_drive(1'b1, 1'b0, 14'h040, 32'h0);
        tick();
        m0_drive(1'b0, 1'b0, '0, '0);
        tick(); tick();
        check("drop_ack", bus.m0_ack, 1'b1);
        check("drop_rdata", bus.m0_rdata, 32'h44444444);
        tick();
        tick();
        check("drop_no_retrigger", bus.busy, 1'b0);

        // both masters requesting continuously, from a fresh reset
        reset_pulse();
        m0_drive(1'b1, 1'b0, 14'h001, 32'h0);
        m1_drive(1'b1, 1'b0, 14'h002, 32'h0);
        for (int t = 0; t < 4; t++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            exp_grant = (t % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_grant = 2'b01;
`endif
            tick();
            check($sformatf("tie%0d_grant", t), bus.grant, exp_grant);
            tick();
            tick();
            check($sformatf("tie%0d_acks", t), {bus.m1_ack, bus.m0_ack}, exp_grant);
            if (exp_grant[0]) begin
                check($sformatf("tie%0d_rdata", t), bus.m0_rdata, 32'h11111111);
            end else begin
                check($sformatf("tie%0d_rdata", t), bus.m1_rdata, 32'h22222222);
            end
            tick();
            check($sformatf("tie%0d_idle", t), bus.busy, 1'b0);
        end
        m0_drive(1'b0, 1'b0, '0, '0);
        m1_drive(1'b0, 1'b0, '0, '0);
        tick();
        check("end_idle", bus.busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL provide the following parameters, one per line: name, default, meaning.
- ADDR_W  14  word-address width of the shared data memory.
- DATA_W  32  data width.
REQ-002 The block SHALL provide the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- m0_req / m1_req  in  1  access request (m0 = CPU datapath, m1 = loader/debug port).
- m0_we / m1_we  in  1  1 = write, 0 = read; qualified by req.
- m0_addr / m1_addr  in  ADDR_W  word address.
- m0_wdata / m1_wdata  in  DATA_W  write data.
- m0_ack / m1_ack  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  DATA_W  read data, valid while ack=1.
- mem_en  out  1  memory enable, sampled by the synchronous RAM.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  RAM output, valid one cycle after mem_en.
- grant  out  2  one-hot owner of the current transaction (bit0 = m0); 00 when idle.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT and DONE.
REQ-004 In IDLE, if any req is high at a rising edge, the FSM SHALL latch the winner's we, addr and wdata, set grant, and move to ISSUE; otherwise it SHALL stay in IDLE.
REQ-005 In ISSUE, mem_en SHALL be 1, mem_we SHALL equal the latched we, and mem_addr and mem_wdata SHALL be driven from the latched values; the next state SHALL be WAIT.
REQ-006 In WAIT, mem_en SHALL be 0, and on a read the block SHALL capture mem_rdata into an internal rdata register at the edge leaving WAIT; the next state SHALL be DONE.
REQ-007 In DONE, only the granted master's ack SHALL be 1, its rdata SHALL present the captured value, and the next state SHALL be IDLE unconditionally.
REQ-008 Latency SHALL be 3 cycles from the edge that samples req to the cycle in which ack is high; minimum spacing between accepted transactions SHALL be 4 cycles.
REQ-009 On a write, rdata SHALL hold its previous value and ack SHALL pulse exactly as it does on a read.
REQ-010 A requester SHALL hold req, we, addr and wdata stable until ack; a req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-011 A req deasserted after a grant SHALL NOT abort the transaction; ack SHALL still pulse.
REQ-012 A req of the non-granted master during ISSUE, WAIT or DONE SHALL be held off (no ack) and arbitrated in the next IDLE.
REQ-013 The arbitration policy SHALL follow REQ-017 and REQ-018; with a single requester active, that requester SHALL always win.
REQ-014 The non-granted master's ack SHALL be 0 at all times; its rdata SHALL be 0.

Reset
REQ-015 While rst=1, the block SHALL immediately (asynchronously) force: state IDLE, grant=00, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, m0_ack=m1_ack=0, rdata register=0, last_grant=1.
REQ-016 Reset asserted mid-transaction SHALL abandon it with no ack; on the first edge after rst falls, arbitration SHALL restart from IDLE.

Configuration
REQ-017 With macro DMEM_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the master other than last_grant, and last_grant SHALL update on every grant (reset value 1, so m0 wins the first tie).
REQ-018 Without DMEM_ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority with m0 always winning ties, and last_grant SHALL be absent or unused.

Verification
REQ-019 m0 read, addr=0x010, mem_rdata=0xDEADBEEF in WAIT -> mem_en high in exactly 1 cycle; m0_ack high 3 cycles after the request edge with m0_rdata=0xDEADBEEF; grant=01 during busy.
REQ-020 m1 write, addr=0x3FF, wdata=0x12345678 -> mem_en=1, mem_we=1, mem_addr=0x3FF, mem_wdata=0x12345678 in ISSUE; m1_ack pulses once; m1_rdata unchanged.
REQ-021 Both req held high continuously with ROUND_ROBIN_EN -> grants alternate m0, m1, m0, m1 at 4-cycle spacing; without the macro -> m0 granted every time, m1 starved.
REQ-022 m1_req rises during an m0 WAIT -> no m1_ack until the m0 DONE cycle has passed; m1 granted in the next IDLE.
REQ-023 rst pulsed during WAIT of an m0 read -> m0_ack never asserts; all outputs read 0 and busy=0 within the reset cycle; a fresh m0 read afterwards completes normally.
REQ-024 m0_req dropped in the ISSUE cycle -> transaction completes and m0_ack still pulses in DONE.
